divremsqrt_iter_fsm: RTL and testbench

DIVREMSQRT_ITER_FSM -- requirements
Module: divremsqrt_iter_fsm

---
 rtl/divremsqrt_iter_fsm_pkg.sv | 14 +
 rtl/divremsqrt_itercnt.sv | 54 +++++
 rtl/divremsqrt_iter_fsm.sv | 126 ++++++++++++
 tb/tb_divremsqrt_iter_fsm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divremsqrt_iter_fsm_pkg.sv
// Shared definitions for the iterative divide/remainder/sqrt sequencer.
//   CntwDefault  : default iteration-counter width
//   iter_state_e : sequencer state encoding (IDLE, BUSY, DONE)
package divremsqrt_iter_fsm_pkg;

  localparam int unsigned CntwDefault = 7;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } iter_state_e;

endpackage

// File: rtl/divremsqrt_itercnt.sv
// Iteration counter for the divide/remainder/sqrt sequencer.
// A loadable down-counter (loaded with max(cycles,1), never decrements below 1)
// with an ==1 detect, plus a saturating count of iterations executed.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load count from cycles, clear step
//   cycles       : full iteration count (0 treated as 1)
//   en           : one iteration executed this cycle
//   last         : count is 1 (this is the final iteration)
//   step         : iterations executed since load (saturating)
module divremsqrt_itercnt #(
  parameter int unsigned CNTW = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [CNTW-1:0] cycles,
  input  logic            en,
  output logic            last,
  output logic [CNTW-1:0] step
);

  localparam logic [CNTW-1:0] One     = CNTW'(1);
  localparam logic [CNTW-1:0] StepMax = '1;

  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] step_q, step_d;

  always_comb begin
    count_d = count_q;
    step_d  = step_q;
    if (load) begin
      count_d = (cycles == '0) ? One : cycles;
      step_d  = '0;
    end else if (en) begin
      if (count_q > One) count_d = count_q - One;
      if (step_q != StepMax) step_d = step_q + One;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      step_q  <= '0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign last = (count_q == One);
  assign step = step_q;

endmodule

// File: rtl/divremsqrt_iter_fsm.sv
// Sequencer for the iterative divide/remainder/square-root unit.
// Accepts an operation in IDLE, runs the recurrence for CyclesE iterations in
// BUSY (optionally ending early when the residual reaches zero) and presents
// the result in DONE until downstream takes it. FlushE aborts from any state.
// Build option: define DIVREMSQRT_EARLYTERM_EN to let WZeroE shorten the
// operation; otherwise WZeroE only records exactness.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   StartE          : begin an operation (honoured only in IDLE)
//   SpecialCaseE    : operand special case, go straight to DONE
//   CyclesE         : full iteration count, sampled on accepted StartE
//   WZeroE          : residual is zero (valid in BUSY)
//   StallM          : downstream not ready, hold DONE
//   FlushE          : abort, return to IDLE
//   IterLoadE       : load initial residual/quotient
//   IterEnE         : advance the recurrence this cycle
//   BusyE           : operation in flight (BUSY or DONE)
//   DoneM           : result valid
//   ExactM          : residual reached zero during the operation
//   StepM           : iterations executed
module divremsqrt_iter_fsm
  import divremsqrt_iter_fsm_pkg::*;
#(
  parameter int unsigned CNTW   = CntwDefault,
  parameter int unsigned MINCYC = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic            SpecialCaseE,
  input  logic [CNTW-1:0] CyclesE,
  input  logic            WZeroE,
  input  logic            StallM,
  input  logic            FlushE,
  output logic            IterLoadE,
  output logic            IterEnE,
  output logic            BusyE,
  output logic            DoneM,
  output logic            ExactM,
  output logic [CNTW-1:0] StepM
);

`ifdef DIVREMSQRT_EARLYTERM_EN
  localparam bit EarlyTermEn = 1'b1;
`else
  localparam bit EarlyTermEn = 1'b0;
`endif

  localparam logic [CNTW-1:0] MinCyc = CNTW'(MINCYC);

  iter_state_e     state_q, state_d;
  logic            done_q, exact_q, exact_d;
  logic            cnt_load, iter_en, cnt_last, early;
  logic [CNTW-1:0] step;

  divremsqrt_itercnt #(
    .CNTW (CNTW)
  ) u_itercnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .cycles  (CyclesE),
    .en      (iter_en),
    .last    (cnt_last),
    .step    (step)
  );

  // step is the count before this cycle's iteration, so early exit needs
  // at least MINCYC completed iterations ahead of the one reporting zero.
  assign early = EarlyTermEn && WZeroE && (step >= MinCyc);

  always_comb begin
    state_d   = state_q;
    exact_d   = exact_q;
    cnt_load  = 1'b0;
    iter_en   = 1'b0;
    IterLoadE = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (StartE && !FlushE) begin
          // Special cases also load so StepM reads 0 in DONE.
          cnt_load = 1'b1;
          exact_d  = 1'b0;
          if (SpecialCaseE) begin
            state_d = StDone;
          end else begin
            IterLoadE = reset_n;
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        if (FlushE) begin
          state_d = StIdle;
        end else begin
          iter_en = 1'b1;
          if (WZeroE) exact_d = 1'b1;
          if (cnt_last || early) state_d = StDone;
        end
      end
      StDone: begin
        if (FlushE || !StallM) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == StDone);
      exact_q <= exact_d;
    end
  end

  assign IterEnE = iter_en;
  assign BusyE   = (state_q != StIdle);
  assign DoneM   = done_q;
  assign ExactM  = exact_q;
  assign StepM   = step;

endmodule

// File: tb/tb_divremsqrt_iter_fsm.sv
module tb_divremsqrt_iter_fsm;

  localparam int CNTW   = 7;
  localparam int MinCyc = 1;
`ifdef DIVREMSQRT_EARLYTERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            StartE = 1'b0, SpecialCaseE = 1'b0, WZeroE = 1'b0;
  logic            StallM = 1'b0, FlushE = 1'b0;
  logic [CNTW-1:0] CyclesE = '0;
  logic            IterLoadE, IterEnE, BusyE, DoneM, ExactM;
  logic [CNTW-1:0] StepM;

  divremsqrt_iter_fsm dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .StartE       (StartE),
    .SpecialCaseE (SpecialCaseE),
    .CyclesE      (CyclesE),
    .WZeroE       (WZeroE),
    .StallM       (StallM),
    .FlushE       (FlushE),
    .IterLoadE    (IterLoadE),
    .IterEnE      (IterEnE),
    .BusyE        (BusyE),
    .DoneM        (DoneM),
    .ExactM       (ExactM),
    .StepM        (StepM)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected outputs for the current cycle, set by the driver.
  bit chk_on = 1'b0;
  bit exp_load, exp_en, exp_busy, exp_done, exp_se, exp_exact;
  int exp_step;

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("IterLoadE", int'(IterLoadE), int'(exp_load));
      chk("IterEnE", int'(IterEnE), int'(exp_en));
      chk("BusyE", int'(BusyE), int'(exp_busy));
      chk("DoneM", int'(DoneM), int'(exp_done));
      if (exp_se) begin
        chk("StepM", int'(StepM), exp_step);
        chk("ExactM", int'(ExactM), int'(exp_exact));
      end
    end
  end

  // Operation-level model: busy cycles run 1..t, result valid from t+1.
  task automatic model(input int cyc, input bit special, input bit [255:0] wz,
                       output int t, output int step, output bit exact);
    int n;
    exact = 1'b0;
    if (special) begin
      t = 0;
    end else begin
      n = (cyc == 0) ? 1 : cyc;
      t = n;
      for (int k = 1; k <= n; k++) begin
        if (wz[k]) exact = 1'b1;
        // k-1 iterations are already complete when cycle k reports zero
        if (EarlyTerm && wz[k] && (k - 1) >= MinCyc) begin
          t = k;
          break;
        end
      end
    end
    step = (t > (1 << CNTW) - 1) ? (1 << CNTW) - 1 : t;
  endtask

  task automatic rand_side();
    SpecialCaseE = 1'($urandom_range(1));
    CyclesE      = CNTW'($urandom_range(127));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rand_side();
      StartE = 1'($urandom_range(1));
      FlushE = StartE;  // a flushed start must be ignored
      WZeroE = 1'($urandom_range(1));
      StallM = 1'($urandom_range(1));
      {exp_load, exp_en, exp_busy, exp_done, exp_se} = '0;
      @(negedge clk);
    end
  endtask

  // flush_at: 0 = none, else cycle index (1..) of the op at which FlushE is raised.
  task automatic run_op(input int cyc, input bit special, input bit [255:0] wz,
                        input int stall, input int flush_at,
                        output int done_cyc, output int en_cnt,
                        output int step_obs, output int exact_obs);
    int t, mstep, last_c;
    bit mexact;
    model(cyc, special, wz, t, mstep, mexact);
    done_cyc = -1; en_cnt = 0; step_obs = -1; exact_obs = -1;
    last_c = t + 1 + stall;
    if (flush_at > 0 && flush_at < last_c) last_c = flush_at;

    @(posedge clk); #1;
    StartE = 1'b1; SpecialCaseE = special; CyclesE = CNTW'(cyc); FlushE = 1'b0;
    WZeroE = 1'($urandom_range(1)); StallM = 1'($urandom_range(1));
    exp_load = !special; {exp_en, exp_busy, exp_done, exp_se} = '0;
    @(negedge clk);
    if (IterEnE) en_cnt++;

    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      rand_side();
      StartE   = 1'($urandom_range(1));
      FlushE   = (c == flush_at);
      exp_load = 1'b0;
      exp_busy = 1'b1;
      if (c <= t) begin
        WZeroE   = wz[c];
        StallM   = 1'($urandom_range(1));
        exp_en   = !FlushE;
        exp_done = 1'b0;
        exp_se   = 1'b0;
      end else begin
        WZeroE    = 1'($urandom_range(1));
        StallM    = ((c - t - 1) < stall);
        exp_en    = 1'b0;
        exp_done  = 1'b1;
        exp_se    = 1'b1;
        exp_step  = mstep;
        exp_exact = mexact;
      end
      @(negedge clk);
      if (IterEnE) en_cnt++;
      if (DoneM && done_cyc < 0) begin
        done_cyc  = c;
        step_obs  = int'(StepM);
        exact_obs = int'(ExactM);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [255:0] wz;
    int dc, ec, so, xo, cyc, stall, fl;
    bit sp;

    #1 reset_n = 1'b0;
    #1;
    chk("reset_IterLoadE", int'(IterLoadE), 0);
    chk("reset_IterEnE", int'(IterEnE), 0);
    chk("reset_BusyE", int'(BusyE), 0);
    chk("reset_DoneM", int'(DoneM), 0);
    chk("reset_ExactM", int'(ExactM), 0);
    chk("reset_StepM", int'(StepM), 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    {exp_load, exp_en, exp_busy, exp_done, exp_se} = '0;
    chk_on = 1'b1;
    idle(2);

    // Full count of 5
    wz = '0;
    run_op(5, 1'b0, wz, 0, 0, dc, ec, so, xo);
    chk("c5_done_cycle", dc, 6);
    chk("c5_iteren_pulses", ec, 5);
    chk("c5_step", so, 5);
    chk("c5_exact", xo, 0);

    // Residual zero on the 4th busy cycle of 20
    wz = '0; wz[4] = 1'b1;
    run_op(20, 1'b0, wz, 0, 0, dc, ec, so, xo);
`ifdef DIVREMSQRT_EARLYTERM_EN
    chk("c20_early_done_cycle", dc, 5);
    chk("c20_early_step", so, 4);
`else
    chk("c20_full_done_cycle", dc, 21);
    chk("c20_full_step", so, 20);
`endif
    chk("c20_exact", xo, 1);

    // Special case goes straight to DONE
    wz = '0;
    run_op(9, 1'b1, wz, 0, 0, dc, ec, so, xo);
    chk("special_done_cycle", dc, 1);
    chk("special_step", so, 0);
    chk("special_iteren_pulses", ec, 0);

    // Stalled result held 3 cycles
    run_op(7, 1'b0, wz, 3, 0, dc, ec, so, xo);
    chk("stall_done_cycle", dc, 8);
    chk("stall_step", so, 7);

    // Flush at busy cycle 2, then an immediate new start
    run_op(10, 1'b0, wz, 0, 2, dc, ec, so, xo);
    chk("flush_no_done", dc, -1);
    chk("flush_iteren_pulses", ec, 1);
    run_op(3, 1'b0, wz, 0, 0, dc, ec, so, xo);
    chk("after_flush_done_cycle", dc, 4);

    // Zero count treated as one; final-cycle zero marks exact
    wz = '0; wz[1] = 1'b1;
    run_op(0, 1'b0, wz, 1, 0, dc, ec, so, xo);
    chk("c0_done_cycle", dc, 2);
    chk("c0_step", so, 1);
    chk("c0_exact", xo, 1);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    StartE = 1'b1; SpecialCaseE = 1'b0; CyclesE = 7'd10; FlushE = 1'b0; WZeroE = 1'b0;
    exp_load = 1'b1; {exp_en, exp_busy, exp_done, exp_se} = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      StartE = 1'b0; exp_load = 1'b0; exp_en = 1'b1; exp_busy = 1'b1;
    end
    #2 chk_on = 1'b0; reset_n = 1'b0;
    #1;
    chk("midreset_IterEnE", int'(IterEnE), 0);
    chk("midreset_BusyE", int'(BusyE), 0);
    chk("midreset_DoneM", int'(DoneM), 0);
    chk("midreset_ExactM", int'(ExactM), 0);
    chk("midreset_StepM", int'(StepM), 0);
    @(posedge clk); #3 reset_n = 1'b1;
    StartE = 1'b0;
    {exp_load, exp_en, exp_busy, exp_done, exp_se} = '0;
    chk_on = 1'b1;
    idle(14);

    // Randomized operations
    for (int n = 0; n < 120; n++) begin
      cyc = ($urandom_range(9) == 0) ? $urandom_range(127) : $urandom_range(24);
      sp  = ($urandom_range(7) == 0);
      wz  = '0;
      for (int k = 1; k < 128; k++) wz[k] = ($urandom_range(15) == 0);
      stall = $urandom_range(3);
      fl  = ($urandom_range(7) == 0) ? $urandom_range(cyc + 2, 1) : 0;
      run_op(cyc, sp, wz, stall, fl, dc, ec, so, xo);
      if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
    end

    idle(2);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
